// File: rtl/i2c_pkg.sv
// i2c_pkg: shared states, quarter indices and frame-length helper for the I2C masters.
package i2c_pkg;
   typedef enum logic [2:0] {IDLE, START, ADDR, ACK, DATA, STOP} state_t;
   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;
   localparam logic [3:0] ACK_SLOT = 4'd8;
   // Quarters in a frame: START, 36 per byte on the wire (address byte included), STOP.
   function automatic int frame_quarters(input int bytes_on_wire);
      return 4 + 36 * bytes_on_wire + 4;
   endfunction
endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: quarter-period tick, high on the last clk of every CLK_DIV-cycle quarter while enabled.
module i2c_tick_gen #(
   parameter int CLK_DIV = 250
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
   logic [W-1:0] cnt_q;
   assign tick = en && (cnt_q == LAST);
   always_ff @(posedge clk) begin
      if (rst || !en) cnt_q <= '0;
      else cnt_q <= tick ? '0 : cnt_q + 1'b1;
   end
endmodule

// File: rtl/i2c_write_master.sv
// i2c_write_master: write-only I2C master sending {SLAVE_ADDR,W} then N_BYTES payload bytes.
module i2c_write_master
   import i2c_pkg::*;
#(
   parameter int         N_BYTES    = 2,
   parameter logic [6:0] SLAVE_ADDR = 7'h3C,
   parameter int         CLK_DIV    = 250
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_signal,
   input  logic [8*N_BYTES-1:0] data_i,
   inout  wire                  sda,
   output logic                 scl,
   output logic                 busy,
   output logic                 done,
   output logic                 ack_err
);
   localparam int DW = 8 * N_BYTES;
   localparam int BW = $clog2(N_BYTES + 1);
   localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, 1'b0};

   state_t state_q, state_d;
   logic [1:0] qtr_q, qtr_d;
   logic [3:0] bit_q, bit_d;
   logic [BW-1:0] byte_q, byte_d;
   logic [DW-1:0] shift_q, shift_d;
   logic start_q, scl_q, scl_d, sda_oe_q, sda_oe_d, busy_q, done_q, done_d, ack_err_q, ack_err_d;
   logic tick, sda_bit;

   i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk (clk),
      .rst (rst),
      .en  (busy_q),
      .tick(tick)
   );

   always_comb begin
      state_d   = state_q;
      qtr_d     = qtr_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      shift_d   = shift_q;
      ack_err_d = ack_err_q;
      done_d    = 1'b0;
      if (state_q == IDLE) begin
         if (start_signal && !start_q) begin
            state_d   = START;
            qtr_d     = Q0;
            bit_d     = '0;
            byte_d    = '0;
            shift_d   = data_i;
            ack_err_d = 1'b0;
         end
      end else if (tick) begin
         qtr_d = qtr_q + 2'd1;
         if (state_q == ACK && qtr_q == Q2 && sda) ack_err_d = 1'b1;
         if (qtr_q == Q3) begin
            case (state_q)
               START: begin
                  state_d = ADDR;
                  bit_d   = '0;
               end
               ADDR, DATA: begin
                  if (state_q == DATA) shift_d = shift_q << 1;
                  if (bit_q == 4'd7) begin
                     state_d = ACK;
                     bit_d   = ACK_SLOT;
                     if (state_q == DATA) byte_d = byte_q + 1'b1;
                  end else begin
                     bit_d = bit_q + 4'd1;
                  end
               end
               // ack_err_q can only have been set by this slot's sample: it is cleared on accept.
               ACK: begin
                  state_d = (ack_err_q || byte_q == BW'(N_BYTES)) ? STOP : DATA;
                  bit_d   = '0;
               end
               STOP: begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
               default: ;
            endcase
         end
      end
      sda_bit  = (state_d == ADDR) ? ADDR_BYTE[~bit_d[2:0]] : shift_d[DW-1];
      scl_d    = (state_d == ADDR || state_d == DATA || state_d == ACK) ? qtr_d[1] :
                 !(state_d == STOP && qtr_d == Q0);
      sda_oe_d = (state_d == START) ? qtr_d[1] :
                 (state_d == STOP) ? !qtr_d[1] :
                 (state_d == ADDR || state_d == DATA) ? !sda_bit : 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         qtr_q     <= Q0;
         bit_q     <= '0;
         byte_q    <= '0;
         shift_q   <= '0;
         start_q   <= 1'b1;
         scl_q     <= 1'b1;
         sda_oe_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         qtr_q     <= qtr_d;
         bit_q     <= bit_d;
         byte_q    <= byte_d;
         shift_q   <= shift_d;
         start_q   <= start_signal;
         scl_q     <= scl_d;
         sda_oe_q  <= sda_oe_d;
         busy_q    <= (state_d != IDLE);
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
      end
   end

   assign sda     = sda_oe_q ? 1'b0 : 1'bz;
   assign scl     = scl_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign ack_err = ack_err_q;
endmodule

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master: directed vectors against two masters with a byte-decoding, ACK-driving slave model.
module tb_i2c_write_master;
   typedef struct {
      int          s;
      int          nack;
      logic [15:0] d;
      int          nb;
      logic [23:0] bytes;
      int          lat;
      logic        err;
      logic        gl;
      int          rst_at;
   } vec_t;

   logic clk = 1'b0;
   logic rst, start_a, start_b;
   logic [15:0] data_a;
   logic [7:0] data_b;
   wire sda_a, sda_b;
   logic scl_a, scl_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
   int pass_cnt = 0;
   int total = 0;
   int nack_at [2];
   logic [1:0] inf, ack, drv, pscl, psda;
   int bitc [2];
   int nrx [2];
   logic [7:0] shr [2];
   logic [7:0] rx [2][4];
   vec_t tbl [8];

   always #5 clk = ~clk;

   pullup (sda_a);
   pullup (sda_b);
   assign sda_a = drv[0] ? 1'b0 : 1'bz;
   assign sda_b = drv[1] ? 1'b0 : 1'bz;

   wire [1:0] scl_w  = {scl_b, scl_a};
   wire [1:0] sda_w  = {sda_b, sda_a};
   wire [1:0] busy_w = {busy_b, busy_a};
   wire [1:0] done_w = {done_b, done_a};
   wire [1:0] err_w  = {err_b, err_a};

   i2c_write_master #(.N_BYTES(2), .SLAVE_ADDR(7'h3C), .CLK_DIV(4)) dut_a (
      .clk(clk), .rst(rst), .start_signal(start_a), .data_i(data_a),
      .sda(sda_a), .scl(scl_a), .busy(busy_a), .done(done_a), .ack_err(err_a)
   );

   i2c_write_master #(.N_BYTES(1), .SLAVE_ADDR(7'h3C), .CLK_DIV(2)) dut_b (
      .clk(clk), .rst(rst), .start_signal(start_b), .data_i(data_b),
      .sda(sda_b), .scl(scl_b), .busy(busy_b), .done(done_b), .ack_err(err_b)
   );

   // Slave model: decodes START/STOP, collects bytes on SCL rise, pulls SDA low in ACK slots.
   initial begin
      inf = '0; ack = '0; drv = '0; pscl = '1; psda = '1;
      for (int s = 0; s < 2; s++) begin
         bitc[s] = 0;
         nrx[s] = 0;
         shr[s] = '0;
      end
      forever begin
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            if (rst) begin
               inf[s] = 1'b0; ack[s] = 1'b0; drv[s] = 1'b0; bitc[s] = 0;
            end else if (scl_w[s] && pscl[s] && psda[s] && !sda_w[s]) begin
               inf[s] = 1'b1; bitc[s] = 0; nrx[s] = 0;
            end else if (scl_w[s] && pscl[s] && !psda[s] && sda_w[s]) begin
               inf[s] = 1'b0;
            end else if (inf[s] && scl_w[s] && !pscl[s] && bitc[s] < 8) begin
               shr[s] = {shr[s][6:0], sda_w[s]};
               bitc[s]++;
               if (bitc[s] == 8 && nrx[s] < 4) begin
                  rx[s][nrx[s]] = shr[s];
                  nrx[s]++;
               end
            end else if (inf[s] && !scl_w[s] && pscl[s]) begin
               if (ack[s]) begin
                  drv[s] = 1'b0; ack[s] = 1'b0; bitc[s] = 0;
               end else if (bitc[s] == 8) begin
                  drv[s] = (nrx[s] - 1 != nack_at[s]);
                  ack[s] = 1'b1;
               end
            end
            pscl[s] = scl_w[s];
            psda[s] = sda_w[s];
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      else pass_cnt++;
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %b expected %b", nm, act, exp);
      else pass_cnt++;
   endtask

   task automatic run(input vec_t v);
      int n, div, lat, stab, cnt;
      int vq [$];
      logic ps, pd;
      div = (v.s == 0) ? 4 : 2;
      nack_at[v.s] = v.nack;
      @(negedge clk);
      if (v.s == 0) begin start_a = 1'b0; data_a = v.d; end
      else begin start_b = 1'b0; data_b = v.d[7:0]; end
      @(negedge clk);
      if (v.s == 0) start_a = 1'b1;
      else start_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk1("busy_after_accept", busy_w[v.s], 1'b1);
      chk1("ack_err_cleared_on_accept", err_w[v.s], 1'b0);
      n = 0; lat = 0; ps = scl_w[v.s]; pd = sda_w[v.s];
      while (lat == 0 && n < 3000) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (v.gl && v.s == 0) begin
            if (n == 60) data_a = ~v.d;
            if (n == 95) start_a = 1'b0;
            if (n == 100) start_a = 1'b1;
         end
         if (v.rst_at == n) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk1("rst_scl_high", scl_w[v.s], 1'b1);
            chk1("rst_sda_released", sda_w[v.s], 1'b1);
            chk1("rst_busy_low", busy_w[v.s], 1'b0);
            chk1("rst_done_low", done_w[v.s], 1'b0);
            chk1("rst_ack_err_low", err_w[v.s], 1'b0);
            @(negedge clk);
            rst = 1'b0;
            cnt = 0;
            repeat (600) begin
               @(negedge clk);
               if (done_w[v.s]) cnt++;
            end
            chk("no_done_after_rst", cnt, 0);
            return;
         end
         if (scl_w[v.s] && ps && sda_w[v.s] !== pd && n / div >= 4) vq.push_back(n / div);
         ps = scl_w[v.s];
         pd = sda_w[v.s];
         if (done_w[v.s]) lat = n + 1;
      end
      chk("done_latency", lat, v.lat);
      chk1("busy_low_at_done", busy_w[v.s], 1'b0);
      chk1("ack_err_at_done", err_w[v.s], v.err);
      chk("bytes_on_wire", nrx[v.s], v.nb);
      for (int i = 0; i < v.nb && i < 3; i++) chk($sformatf("wire_byte%0d", i), int'(rx[v.s][i]), int'(v.bytes[23-8*i -: 8]));
      stab = 0;
      foreach (vq[i]) if (vq[i] < n / div - 4) stab++;
      chk("sda_stable_while_scl_high", stab, 0);
      @(negedge clk);
      chk1("done_one_cycle", done_w[v.s], 1'b0);
      repeat (3) @(negedge clk);
      chk1("ack_err_sticky", err_w[v.s], v.err);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //            s  nack  data       nb bytes         lat  err  gl   rst_at
      tbl[0] = '{0, -1, 16'hA55A, 3, 24'h78A55A, 465, 1'b0, 1'b0, 0};
      tbl[1] = '{0,  0, 16'hA55A, 1, 24'h780000, 177, 1'b1, 1'b0, 0};
      tbl[2] = '{0,  1, 16'hA55A, 2, 24'h78A500, 321, 1'b1, 1'b0, 0};
      tbl[3] = '{0,  2, 16'h00FF, 3, 24'h7800FF, 465, 1'b1, 1'b0, 0};
      tbl[4] = '{0, -1, 16'h1234, 3, 24'h781234, 465, 1'b0, 1'b1, 0};
      tbl[5] = '{0, -1, 16'hC3C3, 0, 24'h000000, 0,   1'b0, 1'b0, 200};
      tbl[6] = '{0, -1, 16'h8001, 3, 24'h788001, 465, 1'b0, 1'b0, 0};
      tbl[7] = '{1, -1, 16'h007F, 2, 24'h787F00, 161, 1'b0, 1'b0, 0};
      nack_at[0] = -1;
      nack_at[1] = -1;
      rst = 1'b1; start_a = 1'b1; start_b = 1'b0; data_a = '0; data_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("reset_scl_a", scl_a, 1'b1);
      chk1("reset_sda_a", sda_a, 1'b1);
      chk1("reset_busy_a", busy_a, 1'b0);
      chk1("reset_done_a", done_a, 1'b0);
      chk1("reset_ack_err_a", err_a, 1'b0);
      chk1("reset_scl_b", scl_b, 1'b1);
      chk1("reset_busy_b", busy_b, 1'b0);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk1("held_start_ignored", busy_a, 1'b0);
      for (int i = 0; i < 4; i++) run(tbl[i]);
      run(tbl[4]);
      repeat (20) @(negedge clk);
      chk1("busy_edge_not_queued", busy_a, 1'b0);
      run(tbl[5]);
      run(tbl[6]);
      run(tbl[7]);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
